// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// type and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STORE,
    S_LOAD_ISSUE,
    S_LOAD_CAPTURE
  } lsu_state_t;

  // Number of bytes touched by an access; the low two funct3 bits carry the size.
  function automatic logic [2:0] byte_count(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   byte_count = 3'd1;
      2'b01:   byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_ext.sv
// Load result extender: sign- or zero-extends the low byte/half of the RAM
// read word according to the load width code; words pass unchanged.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  logic signed [7:0]  w_byte_s;
  logic signed [15:0] w_half_s;

  assign w_byte_s = i_data[7:0];
  assign w_half_s = i_data[15:0];

  // Select the extension that matches the load width.
  always_comb begin
    case (i_funct3)
      F3_B:    o_data = 32'(w_byte_s);
      F3_H:    o_data = 32'(w_half_s);
      F3_BU:   o_data = {24'd0, i_data[7:0]};
      F3_HU:   o_data = {16'd0, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a byte-wide data RAM with a registered 32-bit
// little-endian read port. Stores are serialised into one RAM write per byte;
// loads take one issue cycle and one capture cycle. Every request finishes
// with a single-cycle resp_valid pulse that overlaps IDLE.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses
// as errors; otherwise the low address bits are cleared to alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              LSU_clk,
  input  logic              LSU_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_add,
  output logic [7:0]        ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  lsu_state_t        r_state;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;

  logic              w_accept;
  logic              w_f3_ok;
  logic              w_oor;
  logic              w_misalign;
  logic              w_err;
  logic [ADDR_W-1:0] w_addr_al;
  logic              w_last_byte;
  logic [DATA_W-1:0] w_wshift;
  logic [DATA_W-1:0] w_ext_data;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_oor    = |req_addr[DATA_W-1:ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                      ((req_funct3 == F3_W) && (|req_addr[1:0]));
  assign w_addr_al  = req_addr[ADDR_W-1:0];
`else
  // Halves and words silently drop the offending low bits.
  assign w_misalign = 1'b0;
  assign w_addr_al  = (req_funct3[1:0] == 2'b01) ? {req_addr[ADDR_W-1:1], 1'b0}  :
                      (req_funct3[1:0] == 2'b10) ? {req_addr[ADDR_W-1:2], 2'b00} :
                      req_addr[ADDR_W-1:0];
`endif

  // Width code legality differs between stores (no unsigned forms) and loads.
  always_comb begin
    if (req_we) begin
      w_f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
    end else begin
      w_f3_ok = (req_funct3 == F3_B)  || (req_funct3 == F3_H)  || (req_funct3 == F3_W) ||
                (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
    end
  end

  assign w_err       = !w_f3_ok || w_oor || w_misalign;
  assign w_last_byte = ({1'b0, r_cnt} == (byte_count(r_funct3) - 3'd1));
  assign w_wshift    = r_wdata >> {r_cnt, 3'b000};

  lsu_load_ext u_load_ext (
    .i_funct3 (r_funct3),
    .i_data   (ram_out),
    .o_data   (w_ext_data)
  );

  // Request fields are captured on accept; only the FSM needs reset.
  always_ff @(posedge LSU_clk) begin
    if (w_accept) begin
      r_addr   <= w_addr_al;
      r_wdata  <= req_wdata;
      r_funct3 <= req_funct3;
    end
  end

  // Sequencer: accept/check in IDLE, per-byte store walk, two-cycle load, response pulse.
  always_ff @(posedge LSU_clk or posedge LSU_rst) begin
    if (LSU_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (req_we) begin
              r_state <= S_STORE;
            end else begin
              r_state <= S_LOAD_ISSUE;
            end
          end
        end
        S_STORE: begin
          if (w_last_byte) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_LOAD_ISSUE: begin
          r_state <= S_LOAD_CAPTURE;
        end
        S_LOAD_CAPTURE: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= w_ext_data;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // RAM port decoded from state so a reset removes the write strobe at once.
  always_comb begin
    ram_we  = 1'b0;
    ram_add = '0;
    ram_in  = '0;
    case (r_state)
      S_STORE: begin
        ram_we  = 1'b1;
        ram_add = r_addr + ADDR_W'(r_cnt);
        ram_in  = w_wshift[7:0];
      end
      S_LOAD_ISSUE, S_LOAD_CAPTURE: begin
        ram_add = r_addr;
      end
      default: ;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte RAM model with registered little-endian
// read port, a byte-array reference model of memory contents and response
// rules, directed cases, random traffic, back-to-back timing and reset abort.
module tb_load_store_unit;

  logic        LSU_clk = 1'b0;
  logic        LSU_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we;
  logic [5:0]  ram_add;
  logic [7:0]  ram_in;
  logic [31:0] ram_out;

  logic [7:0]  mem     [64];
  logic [7:0]  ref_mem [64];
  bit          ram_init = 1'b1;
  logic [13:0] wr_q   [$];
  logic [13:0] exp_wr [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } dreq_t;

  load_store_unit #(.ADDR_W(6), .DATA_W(32)) dut (
    .LSU_clk    (LSU_clk),
    .LSU_rst    (LSU_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .ram_we     (ram_we),
    .ram_add    (ram_add),
    .ram_in     (ram_in),
    .ram_out    (ram_out)
  );

  always #5 LSU_clk = ~LSU_clk;

  always @(posedge LSU_clk) cyc <= cyc + 1;

  // Data RAM: byte writes, registered 32-bit little-endian read.
  always @(posedge LSU_clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (ram_we) begin
      mem[ram_add] <= ram_in;
    end
    ram_out <= {mem[ram_add + 6'd3], mem[ram_add + 6'd2], mem[ram_add + 6'd1], mem[ram_add]};
  end

  always @(posedge LSU_clk) if (ram_we) wr_q.push_back({ram_add, ram_in});

  // Reference model: outcome of one request derived from the access rules.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output bit e_err, output logic [31:0] e_rd,
                       output int e_lat, output int e_ea);
    bit     legal;
    bit     oor;
    bit     mis;
    int     size;
    int     idx;
    int     b;
    longint v;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    oor   = (addr > 32'd63);
    mis   = ((addr % size) != 0);
`ifdef LSU_MISALIGN_TRAP_EN
    e_err = !legal || oor || mis;
    e_ea  = int'(addr % 64);
`else
    e_err = !legal || oor;
    e_ea  = int'(addr % 64) - int'(addr % size);
`endif
    exp_wr.delete();
    e_rd  = 32'd0;
    if (e_err) begin
      e_lat = 0;
    end else if (we) begin
      e_lat = size;
      for (int k = 0; k < size; k++) begin
        idx = (e_ea + k) % 64;
        b   = int'((wd >> (8 * k)) & 32'hFF);
        ref_mem[idx] = b[7:0];
        exp_wr.push_back({idx[5:0], b[7:0]});
      end
    end else begin
      e_lat = 2;
      v = 0;
      for (int k = 0; k < size; k++) v += longint'(ref_mem[(e_ea + k) % 64]) << (8 * k);
      if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v -= longint'(1) << (8 * size);
      e_rd = v[31:0];
    end
  endtask

  // Present one request now (away from the edge), wait for its response pulse.
  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic o_ready, output int o_lat,
                         output logic o_err, output logic [31:0] o_rd,
                         output logic [5:0] o_add0, output bit o_to);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    o_ready    = req_ready;
    wr_q.delete();
    @(posedge LSU_clk); #1;
    req_valid = 1'b0;
    o_add0 = ram_add;
    o_lat  = 0;
    o_to   = 1'b1;
    o_err  = 1'bx;
    o_rd   = 'x;
    for (int i = 0; i < 16; i++) begin
      if (resp_valid) begin
        o_to  = 1'b0;
        o_err = resp_err;
        o_rd  = resp_rdata;
        break;
      end
      @(posedge LSU_clk); #1;
      o_lat++;
    end
  endtask

  task automatic test_reset();
    @(posedge LSU_clk); @(posedge LSU_clk); #1;
    n_cmp++; if (ram_we !== 1'b0)      begin n_fail++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
    n_cmp++; if (ram_add !== 6'd0)     begin n_fail++; $display("FAIL reset_ram_add got %h want 00", ram_add); end
    n_cmp++; if (ram_in !== 8'd0)      begin n_fail++; $display("FAIL reset_ram_in got %h want 00", ram_in); end
    n_cmp++; if (resp_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_cmp++; if (resp_err !== 1'b0)    begin n_fail++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    n_cmp++; if (resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    ram_init = 1'b0;
    LSU_rst  = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    @(posedge LSU_clk); #1;
  endtask

  task automatic test_directed();
    dreq_t d [11];
    logic rdy; int lat; logic err; logic [31:0] rd; logic [5:0] add0; bit to;
    bit e_err; logic [31:0] e_rd; int e_lat; int e_ea; bit ok;
    d = '{'{1'b1, 3'b010, 32'd8,        32'hDEADBEEF, 32'h00000000},
          '{1'b0, 3'b010, 32'd8,        32'h0,        32'hDEADBEEF},
          '{1'b0, 3'b000, 32'd11,       32'h0,        32'hFFFFFFDE},
          '{1'b0, 3'b100, 32'd11,       32'h0,        32'h000000DE},
          '{1'b0, 3'b001, 32'd10,       32'h0,        32'hFFFFDEAD},
          '{1'b0, 3'b101, 32'd8,        32'h0,        32'h0000BEEF},
          '{1'b1, 3'b001, 32'd3,        32'h00001234, 32'h00000000},
          '{1'b0, 3'b011, 32'd4,        32'h0,        32'h00000000},
          '{1'b0, 3'b010, 32'h40,       32'h0,        32'h00000000},
          '{1'b1, 3'b000, 32'h40,       32'h000000A5, 32'h00000000},
          '{1'b1, 3'b100, 32'd5,        32'h000000A5, 32'h00000000}};
    foreach (d[i]) begin
      model(d[i].we, d[i].f3, d[i].addr, d[i].wd, e_err, e_rd, e_lat, e_ea);
      run_req(d[i].we, d[i].f3, d[i].addr, d[i].wd, rdy, lat, err, rd, add0, to);
      n_cmp++;
      if (to || rdy !== 1'b1 || err !== e_err || lat != e_lat || rd !== d[i].rd) begin
        n_fail++;
        $display("FAIL dir[%0d] timeout=%0b ready=%b err=%b lat=%0d rdata=%h, required ready=1 err=%b lat=%0d rdata=%h",
                 i, to, rdy, err, lat, rd, e_err, e_lat, d[i].rd);
      end
      ok = (wr_q.size() == exp_wr.size());
      if (ok) foreach (wr_q[j]) if (wr_q[j] !== exp_wr[j]) ok = 1'b0;
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL dir[%0d] ram writes got %p required %p", i, wr_q, exp_wr); end
      if (!d[i].we && !e_err) begin
        n_cmp++;
        if (add0 !== 6'(e_ea)) begin n_fail++; $display("FAIL dir[%0d] load issue addr got %0d want %0d", i, add0, e_ea); end
      end
    end
  endtask

  task automatic test_random();
    logic rdy; int lat; logic err; logic [31:0] rd; logic [5:0] add0; bit to;
    bit e_err; logic [31:0] e_rd; int e_lat; int e_ea; bit ok;
    bit we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      wd = $urandom;
      case ($urandom % 8)
        0:       addr = 32'd64 + ($urandom % 64);
        1:       addr = $urandom;
        default: addr = $urandom % 64;
      endcase
      model(we, f3, addr, wd, e_err, e_rd, e_lat, e_ea);
      run_req(we, f3, addr, wd, rdy, lat, err, rd, add0, to);
      n_cmp++;
      if (to || rdy !== 1'b1 || err !== e_err || lat != e_lat || rd !== e_rd) begin
        n_fail++;
        $display("FAIL rnd[%0d] we=%0b f3=%0d addr=%h timeout=%0b ready=%b err=%b lat=%0d rdata=%h, required err=%b lat=%0d rdata=%h",
                 i, we, f3, addr, to, rdy, err, lat, rd, e_err, e_lat, e_rd);
      end
      ok = (wr_q.size() == exp_wr.size());
      if (ok) foreach (wr_q[j]) if (wr_q[j] !== exp_wr[j]) ok = 1'b0;
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL rnd[%0d] ram writes got %p required %p", i, wr_q, exp_wr); end
    end
  endtask

  task automatic test_back_to_back();
    logic rdy; int lat; logic err; logic [31:0] rd; logic [5:0] add0; bit to;
    bit e_err; logic [31:0] e_rd; int e_lat; int e_ea;
    bit we; logic [2:0] f3; logic [31:0] addr; int t; int start; int exp_cyc;
    start   = cyc;
    exp_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      we = 1'($urandom);
      t  = int'($urandom % (we ? 3 : 5));
      f3 = (t < 3) ? 3'(t) : 3'(t + 1);
      addr = $urandom % 64;
      model(we, f3, addr, $urandom, e_err, e_rd, e_lat, e_ea);
      run_req(we, f3, addr, 32'h5A5A0000 | i, rdy, lat, err, rd, add0, to);
      exp_cyc += e_lat + 1;
      n_cmp++;
      if (to || rdy !== 1'b1 || err !== e_err || lat != e_lat || (!we && rd !== e_rd)) begin
        n_fail++;
        $display("FAIL b2b[%0d] timeout=%0b ready=%b err=%b lat=%0d rdata=%h, required ready=1 err=%b lat=%0d rdata=%h",
                 i, to, rdy, err, lat, rd, e_err, e_lat, e_rd);
      end
    end
    n_cmp++;
    if (cyc - start != exp_cyc) begin
      n_fail++; $display("FAIL b2b_cycles got %0d want %0d", cyc - start, exp_cyc);
    end
  endtask

  task automatic test_reset_mid_store();
    logic rdy; int lat; logic err; logic [31:0] rd; logic [5:0] add0; bit to;
    bit e_err; logic [31:0] e_rd; int e_lat; int e_ea; bit ok; bit seen;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'd20; req_wdata = 32'h11223344;
    wr_q.delete();
    @(posedge LSU_clk); #1;
    req_valid = 1'b0;
    @(posedge LSU_clk); #1;
    @(posedge LSU_clk); #1;
    n_cmp++;
    if (ram_we !== 1'b1 || ram_add !== 6'd22 || ram_in !== 8'h22) begin
      n_fail++; $display("FAIL rst_third_byte we=%b add=%0d in=%h want 1 22 22", ram_we, ram_add, ram_in);
    end
    LSU_rst = 1'b1;
    #1;
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we_drop got %b want 0", ram_we); end
    @(posedge LSU_clk); #1;
    LSU_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) seen = 1'b1;
      @(posedge LSU_clk); #1;
    end
    n_cmp++; if (seen) begin n_fail++; $display("FAIL rst_no_resp got resp_valid=1 want 0"); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", req_ready); end
    exp_wr.delete();
    exp_wr.push_back({6'd20, 8'h44});
    exp_wr.push_back({6'd21, 8'h33});
    ok = (wr_q.size() == exp_wr.size());
    if (ok) foreach (wr_q[j]) if (wr_q[j] !== exp_wr[j]) ok = 1'b0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_partial_writes got %p required %p", wr_q, exp_wr); end
    ref_mem[20] = 8'h44;
    ref_mem[21] = 8'h33;
    model(1'b0, 3'b010, 32'd20, 32'd0, e_err, e_rd, e_lat, e_ea);
    run_req(1'b0, 3'b010, 32'd20, 32'd0, rdy, lat, err, rd, add0, to);
    n_cmp++;
    if (to || err !== 1'b0 || rd !== e_rd || rd[15:0] !== 16'h3344) begin
      n_fail++; $display("FAIL rst_partial_load timeout=%0b err=%b rdata=%h required err=0 rdata=%h", to, err, rd, e_rd);
    end
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 8'($urandom);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the byte-wide data RAM (6-bit byte address, 8-bit write port, registered 32-bit little-endian read port).
- Accepts one load/store request at a time from the core's MEM stage.
- Serialises stores into per-byte RAM writes.
- Issues loads and returns sign/zero-extended results with a single-cycle response pulse.

Parameters:
- ADDR_W, 6, byte-address width of the RAM.
- DATA_W, 32, core data width (fixed 32; other values unsupported).

Ports:
- LSU_clk  input  1  clock, rising edge.
- LSU_rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE; request accepted on an edge where valid&&ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, low bytes used.
- resp_valid  output  1  one-cycle completion pulse; no backpressure.
- resp_err  output  1  valid with resp_valid: misaligned, out-of-range or illegal funct3.
- resp_rdata  output  32  load result, 0 for stores/errors.
- ram_we  output  1  RAM write enable.
- ram_add  output  ADDR_W  RAM byte address.
- ram_in  output  8  RAM write byte.
- ram_out  input  32  RAM registered read data.

Behaviour:
- Clock/reset: one clock LSU_clk; LSU_rst is asynchronous, active-high.
- Reset values: state IDLE, req_ready=1 after release, resp_valid=0, resp_err=0, resp_rdata=0, ram_we=0, ram_add=0, ram_in=0, byte counter=0.
- RAM interface: ram_we, ram_add and ram_in are decoded from state and registers, so ram_we drops in the same cycle reset asserts.
- States: IDLE, STORE, LOAD_ISSUE, LOAD_CAPTURE.
- IDLE: req_ready=1, ram_we=0. On accept, latch addr, wdata, funct3 and we, then check validity.
- Error checks:
  - Illegal funct3: stores accept only 000–010; loads accept 000,001,010,100,101.
  - Address out of range: req_addr[31:ADDR_W] != 0.
  - Misaligned access: see Optional Feature.
- Error response: no RAM access; stay IDLE; next cycle resp_valid=1, resp_err=1, resp_rdata=0.
- STORE: n bytes, where n = 1/2/4 for B/H/W.
  - Per cycle k (0..n-1): ram_we=1, ram_add=addr+k, ram_in=wdata[8k+7:8k].
  - After edge k=n-1, go to IDLE and pulse resp_valid, resp_err=0.
  - Latency: accept edge N, resp_valid in cycle after edge N+n.
- LOAD_ISSUE: one cycle with ram_we=0, ram_add=addr; the RAM captures on the next edge.
- LOAD_CAPTURE:
  - Extend ram_out[7:0] or [15:0] per funct3; W passes all 32 bits.
  - Register into resp_rdata, pulse resp_valid, return to IDLE.
  - Latency: accept edge N, resp_valid in cycle after edge N+2.
- Response cycle overlaps IDLE: req_ready=1 there, so back-to-back requests lose no cycle.
- Byte addresses beyond the top for an aligned H at 62 are unused, since only the low bytes are consumed.
- Reset mid-operation: immediate return to IDLE. A store is left partial (bytes written before the reset edge stay written). No response is issued.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: H with addr[0]=1, or W with addr[1:0]!=0, gives an error response and no RAM access.
- Undefined: low address bits are forced to alignment (H clears bit0, W clears bits1:0) and the access proceeds; resp_err is never set for misalignment.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t;
  - function byte_count(funct3).
- One natural sub-module: lsu_load_ext, a combinational sign/zero extender (funct3 + 32-bit in → 32-bit out).

Test Plan:
- Reset, then SW addr 8, data 0xDEADBEEF → ram_we high 4 cycles, ram_add 8,9,10,11, ram_in EF,BE,AD,DE; resp_valid one cycle after, resp_err=0.
- LW addr 8 → one ram_we=0 cycle with ram_add=8; resp_rdata=0xDEADBEEF, resp_valid in 3rd cycle after accept.
- LB 11 → 0xFFFFFFDE; LBU 11 → 0x000000DE; LH 10 → 0xFFFFDEAD; LHU 8 → 0x0000BEEF.
- SH addr 3, data 0x1234:
  - macro defined → resp_err=1, no ram_we;
  - undefined → writes 34@2, 12@3.
- Illegal load funct3=011, or addr 0x40 → resp_err=1, resp_rdata=0, no RAM write.
- SW 0x11223344 @20, LSU_rst pulsed during 3rd byte → ram_we low at once, bytes 20,21 hold 44,33, LW 20 after release returns the partial word.
